// File: rtl/shf_pkg.sv
// Shared definitions for the sequenced shift/rotate controller: operation codes,
// FSM state encoding and an operation-legality helper.
package shf_pkg;

  localparam logic [2:0] OP_SRL = 3'd0;
  localparam logic [2:0] OP_SRA = 3'd1;
  localparam logic [2:0] OP_ROR = 3'd2;
  localparam logic [2:0] OP_SLL = 3'd3;
  localparam logic [2:0] OP_ROL = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  function automatic logic oper_legal(input logic [2:0] op);
    return (op == OP_SRL) || (op == OP_SRA) || (op == OP_ROR) ||
           (op == OP_SLL) || (op == OP_ROL);
  endfunction

endpackage

// File: rtl/shf_stage.sv
// One logarithmic shift/rotate stage: shifts by the power of two picked by a
// one-hot select. Illegal operation codes yield zero.
module shf_stage
  import shf_pkg::*;
#(
  parameter int WIDTH = 8,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [2:0]       oper,
  input  logic [AMT_W-1:0] sel,
  output logic [WIDTH-1:0] res
);

  logic [WIDTH-1:0] cand [AMT_W];

  genvar gi;
  generate
    for (gi = 0; gi < AMT_W; gi++) begin : g_cand
      localparam int SH = 1 << gi;
      logic [WIDTH-1:0] sra_val;
      assign sra_val = WIDTH'($signed(data) >>> SH);
      assign cand[gi] = (oper == OP_SRL) ? (data >> SH) :
                        (oper == OP_SRA) ? sra_val :
                        (oper == OP_ROR) ? ((data >> SH) | (data << (WIDTH - SH))) :
                        (oper == OP_SLL) ? (data << SH) :
                        (oper == OP_ROL) ? ((data << SH) | (data >> (WIDTH - SH))) :
                        '0;
    end
  endgenerate

  always_comb begin
    res = '0;
    for (int i = 0; i < AMT_W; i++) begin
      if (sel[i]) res = res | cand[i];
    end
  end

endmodule

// File: rtl/shf_seq_ctrl.sv
// Sequencing controller: applies shift stages 1,2,4.. one per clock through a
// single shared shf_stage. Define SHF_SEQ_SKIP_EN for early termination.
module shf_seq_ctrl
  import shf_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_oper,
  input  logic [WIDTH-1:0] req_x,
  input  logic [WIDTH-1:0] req_y,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_r,
  output logic             busy
);

  localparam int AMT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic [AMT_W-1:0] k_q, k_d;
  logic [AMT_W-1:0] amt_q, amt_d;
  logic [2:0]       oper_q, oper_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [WIDTH-1:0] stage_res;
  logic [AMT_W-1:0] stage_sel;
  logic             accept;
  logic             last_stage;
  logic             skip_on_accept;
  logic             unused_y;

  assign unused_y = ^req_y[WIDTH-1:AMT_W];
  assign accept   = req_valid && (state_q == IDLE);
  assign stage_sel = AMT_W'(1) << k_q;

`ifdef SHF_SEQ_SKIP_EN
  // Finish once no amount bit remains above the stage being applied now.
  assign last_stage     = ((amt_q >> k_q) >> 1) == '0;
  assign skip_on_accept = (req_y[AMT_W-1:0] == '0) || !oper_legal(req_oper);
`else
  assign last_stage     = (k_q == AMT_W'(AMT_W - 1));
  assign skip_on_accept = 1'b0;
`endif

  shf_stage #(.WIDTH(WIDTH)) u_stage (
    .data (data_q),
    .oper (oper_q),
    .sel  (stage_sel),
    .res  (stage_res)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      k_q    <= '0;
      amt_q  <= '0;
      oper_q <= '0;
      data_q <= '0;
    end else begin
      k_q    <= k_d;
      amt_q  <= amt_d;
      oper_q <= oper_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = skip_on_accept ? DONE : SHIFT;
      SHIFT:   if (last_stage) state_d = DONE;
      DONE:    if (resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    k_d    = k_q;
    amt_d  = amt_q;
    oper_d = oper_q;
    data_d = data_q;
    if (state_q == IDLE && accept) begin
      k_d    = '0;
      amt_d  = req_y[AMT_W-1:0];
      oper_d = req_oper;
      // Illegal operations start from zero so an early exit still returns 0.
      data_d = oper_legal(req_oper) ? req_x : '0;
    end else if (state_q == SHIFT) begin
      if (amt_q[k_q] || !oper_legal(oper_q)) data_d = stage_res;
      k_d = k_q + 1'b1;
    end
  end

  always_comb begin
    req_ready  = (state_q == IDLE);
    resp_valid = (state_q == DONE);
    busy       = (state_q == SHIFT) || (state_q == DONE);
    resp_r     = (state_q == DONE) ? data_q : '0;
  end

endmodule

// File: tb/tb_shf_seq_ctrl.sv
// Self-checking bench for shf_seq_ctrl (default build) against an arithmetic
// reference model of the shift/rotate operations.
module tb_shf_seq_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic [2:0] req_oper;
  logic [7:0] req_x;
  logic [7:0] req_y;
  logic       resp_valid;
  logic       resp_ready;
  logic [7:0] resp_r;
  logic       busy;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  shf_seq_ctrl #(.WIDTH(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_oper   (req_oper),
    .req_x      (req_x),
    .req_y      (req_y),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_r     (resp_r),
    .busy       (busy)
  );

  function automatic logic [7:0] ref_shift(input logic [2:0] op, input logic [7:0] x,
                                           input logic [7:0] y);
    int a = int'(y) % 8;
    int v = int'(x);
    case (op)
      3'd0: v = v >> a;
      3'd1: for (int i = 0; i < a; i++) v = (v >> 1) | (v & 'h80);
      3'd2: v = (v >> a) | (v << (8 - a));
      3'd3: v = v << a;
      3'd5: v = (v << a) | (v >> (8 - a));
      default: v = 0;
    endcase
    return 8'(v & 'hFF);
  endfunction

  // Stimulus only: one request, wait for response, optional backpressure, handshake.
  task automatic run_txn(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                         input int hold, input bit junk,
                         output logic [7:0] r, output int lat, output bit stable,
                         output bit idle_after, output bit ready_at_req);
    @(negedge clk);
    req_valid = 1'b1; req_oper = op; req_x = x; req_y = y; resp_ready = 1'b0;
    ready_at_req = req_ready;
    @(posedge clk); #1;
    req_valid = junk; req_oper = 3'($urandom); req_x = 8'($urandom); req_y = 8'($urandom);
    lat = 0;
    while (!resp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    r = resp_r;
    stable = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      if (resp_r !== r || resp_valid !== 1'b1 || req_ready !== 1'b0) stable = 1'b0;
    end
    @(negedge clk);
    req_valid = 1'b0; resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    idle_after = (req_ready === 1'b1) && (busy === 1'b0) && (resp_valid === 1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req_valid = 1'b0; req_oper = '0; req_x = '0; req_y = '0; resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({req_ready, resp_valid, busy, resp_r} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL reset: rdy=%b vld=%b busy=%b r=%h, want 1 0 0 00",
               req_ready, resp_valid, busy, resp_r);
    end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_directed();
    logic [2:0] ops [10] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd4, 3'd0, 3'd1, 3'd5, 3'd0};
    logic [7:0] xs  [10] = '{8'hB4, 8'hB4, 8'h81, 8'h0F, 8'h81, 8'hFF, 8'h80, 8'h5A, 8'h3C, 8'hC3};
    logic [7:0] ys  [10] = '{8'd3, 8'd2, 8'd1, 8'd5, 8'd4, 8'd1, 8'h09, 8'd0, 8'd0, 8'd0};
    logic [7:0] exp [10] = '{8'h16, 8'hED, 8'hC0, 8'hE0, 8'h18, 8'h00, 8'h40, 8'h5A, 8'h3C, 8'hC3};
    logic [7:0] r; int lat; bit st, idl, rdy;
    for (int i = 0; i < 10; i++) begin
      run_txn(ops[i], xs[i], ys[i], 0, 1'b0, r, lat, st, idl, rdy);
      tests_run++;
      if (r !== exp[i] || lat != 3) begin
        tests_failed++;
        $display("FAIL directed[%0d]: op=%0d x=%h y=%h got r=%h lat=%0d, want r=%h lat=3",
                 i, ops[i], xs[i], ys[i], r, lat, exp[i]);
      end else $display("[TB] directed op=%0d x=%h y=%h r=%h lat=%0d", ops[i], xs[i], ys[i], r, lat);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] r; int lat; bit st, idl, rdy;
    run_txn(3'd1, 8'h96, 8'd3, 5, 1'b1, r, lat, st, idl, rdy);
    tests_run++;
    if (r !== ref_shift(3'd1, 8'h96, 8'd3) || !st || !idl) begin
      tests_failed++;
      $display("FAIL backpressure: r=%h stable=%b idle_after=%b, want r=%h 1 1",
               r, st, idl, ref_shift(3'd1, 8'h96, 8'd3));
    end else $display("[TB] backpressure r=%h held 5 cycles", r);
  endtask

  task automatic test_mid_reset();
    bit seen = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_oper = 3'd3; req_x = 8'h01; req_y = 8'd7;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk); rst_n = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({req_ready, resp_valid, busy, resp_r} !== {1'b1, 1'b0, 1'b0, 8'h00}) begin
      tests_failed++;
      $display("FAIL mid_reset: rdy=%b vld=%b busy=%b r=%h, want 1 0 0 00",
               req_ready, resp_valid, busy, resp_r);
    end
    @(negedge clk); rst_n = 1'b1;
    repeat (6) begin
      @(posedge clk); #1;
      if (resp_valid) seen = 1'b1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL mid_reset_noresp: resp_valid seen=1, want 0");
    end else $display("[TB] mid_reset aborted cleanly");
  endtask

  task automatic test_random();
    logic [7:0] r, e; int lat; bit st, idl, rdy;
    logic [2:0] op; logic [7:0] x, y; int hold;
    for (int i = 0; i < 40; i++) begin
      op = 3'($urandom); x = 8'($urandom); y = 8'($urandom); hold = $urandom_range(0, 3);
      e = ref_shift(op, x, y);
      run_txn(op, x, y, hold, 1'($urandom), r, lat, st, idl, rdy);
      tests_run++;
      if (r !== e || lat != 3 || !st || !idl || !rdy) begin
        tests_failed++;
        $display("FAIL random[%0d]: op=%0d x=%h y=%h r=%h lat=%0d st=%b idle=%b rdy=%b, want r=%h lat=3 1 1 1",
                 i, op, x, y, r, lat, st, idl, rdy, e);
      end else $display("[TB] random op=%0d x=%h y=%h r=%h hold=%0d", op, x, y, r, hold);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] r; int lat; bit st, idl, rdy;
    for (int i = 0; i < 4; i++) begin
      run_txn(3'd2, 8'hA5 + 8'(i), 8'(i + 1), 0, 1'b1, r, lat, st, idl, rdy);
      tests_run++;
      if (r !== ref_shift(3'd2, 8'hA5 + 8'(i), 8'(i + 1)) || !rdy || lat != 3) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: r=%h rdy=%b lat=%0d, want r=%h 1 3",
                 i, r, rdy, lat, ref_shift(3'd2, 8'hA5 + 8'(i), 8'(i + 1)));
      end else $display("[TB] back_to_back r=%h", r);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_mid_reset();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
